// File: rtl/counter_pkg.sv
// Shared constants for the multi-mode counter family.
// Mode and direction encodings used by the counter and its wrappers.
package counter_pkg;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler producing one tick every prescale+1 enabled cycles.
// A prescale lowered below the current phase ticks on the next enabled cycle.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             restart,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt >= prescale);

    // Phase counter: restart zeroes it, otherwise it advances while enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (restart) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/multi_mode_counter.sv
// General-purpose counter/timer: prescaled up/down stepping against a limit,
// wrap or saturate at the boundary, terminal-count pulse and sticky overflow.
module multi_mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int PRE_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam bit SAT = (SATURATE == MODE_SAT);

    logic             tick;
    logic             restart;
    logic             at_bound;
    logic             bound_evt;
    logic [WIDTH-1:0] step_val;

    assign restart = clear | load;

    counter_prescaler #(
        .PRE_W (PRE_W)
    ) u_pre (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .restart  (restart),
        .prescale (prescale),
        .tick     (tick)
    );

    // Next value for a step; boundaries are judged against limit and 0 only.
    always_comb begin
        at_bound = 1'b0;
        step_val = count;
        if (up == DIR_UP) begin
            at_bound = (count >= limit);
            step_val = at_bound ? (SAT ? limit : '0) : count + WIDTH'(1);
        end else begin
            at_bound = (count == '0);
            step_val = at_bound ? (SAT ? '0 : limit) : count - WIDTH'(1);
        end
    end

    assign bound_evt = tick & ~restart & at_bound;

    // Count, terminal-count pulse and sticky flag; clear beats load beats step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (load) begin
                count <= load_val;
            end else if (tick) begin
                count <= step_val;
                tc    <= at_bound;
            end
            if (bound_evt) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: doc/multi_mode_counter.md
Name: multi_mode_counter

Overview:
- Parametrised successor to the free-running 32-bit counter.
- Adds configurable width, prescaled stepping, up/down direction, programmable limit, wrap or saturate mode, synchronous load/clear, terminal-count pulse and sticky overflow flag.
- Used as the general-purpose counter/timer primitive under top-level wrappers.
- Also serves as the standard waveform-tracing demo target.

Parameters:
- WIDTH, 32, count/limit/load width (>=2).
- PRE_W, 8, prescaler divide-value width (>=1).
- SATURATE, 0, 0 = wrap at boundary, 1 = hold at boundary.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; gates prescaler and step.
- up  input  1  direction: 1 = up, 0 = down.
- clear  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value for load.
- limit  input  WIDTH  upper boundary (inclusive).
- prescale  input  PRE_W  step every prescale+1 enabled cycles.
- ovf_clr  input  1  clears sticky ovf.
- count  output  WIDTH  current count.
- tc  output  1  one-cycle terminal-count pulse.
- ovf  output  1  sticky boundary-event flag.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset values (asynchronous, immediate): count=0, tc=0, ovf=0, prescaler count=0.
- Prescaler:
  - pre_cnt increments only when en=1.
  - tick=1 when en=1 and pre_cnt==prescale; pre_cnt then returns to 0.
  - prescale=0 gives tick on every enabled cycle.
  - prescale is sampled live; if pre_cnt>prescale after a change, the next enabled cycle ticks and returns pre_cnt to 0.
- Priority per cycle: clear > load > step.
  - clear: count=0, pre_cnt=0, tc=0 next cycle.
  - load: count=load_val, pre_cnt=0, tc=0. load_val is not clamped to limit.
  - step: occurs when tick=1 and neither clear nor load is asserted.
- Up step:
  - count<limit: count+1.
  - count>=limit: boundary event; count=0 if SATURATE=0, else count=limit.
- Down step:
  - count>0: count-1.
  - count==0: boundary event; count=limit if SATURATE=0, else hold 0.
- No arithmetic wraps through 2^WIDTH; all wrap/hold decisions use limit and 0 only.
- Latency: count updates on the clk edge after the tick cycle (registered output, 1 cycle).
- tc: registered; high for exactly one cycle, coincident with the count update caused by a boundary event. In saturate mode, a held boundary re-asserts tc on every further step. This is intended: it indicates "stuck at boundary".
- ovf: set on any boundary event; cleared by ovf_clr. Simultaneous set and clear leaves ovf=1 (set wins).
- limit=0: up and down steps are both boundary events every step; count stays 0 in either mode.
- Reset asserted mid-count aborts immediately. After release, counting resumes from 0 on the first tick.
- en=0 freezes count and pre_cnt. clear/load still act when en=0.

Decomposition:
- Shared package counter_pkg:
  - mode constants MODE_WRAP=0, MODE_SAT=1;
  - direction constants DIR_DOWN=0, DIR_UP=1.
- One sub-module: counter_prescaler (PRE_W; ports clk, reset, en, restart, prescale, tick). restart is driven by clear|load.
- Step/boundary logic and tc/ovf registers live in multi_mode_counter.

Test Plan (WIDTH=8, PRE_W=4):
- Wrap up: SATURATE=0, limit=5, prescale=0, up=1, en=1 for 8 cycles from reset -> count 1,2,3,4,5,0,1,2; tc high only with the 5->0 update; ovf=1 thereafter.
- Saturate down: SATURATE=1, load_val=2 then down, prescale=0, 4 steps -> count 1,0,0,0; tc high on each of the last two steps.
- Prescale: prescale=3, limit=255, en=1 for 12 cycles -> count increments every 4th cycle, reaching 3. Drop en for 5 cycles -> count and phase frozen.
- Priority: clear=1, load=1, load_val=0x42 with a pending tick in the same cycle -> count=0 next cycle, tc=0. Next cycle load only -> count=0x42.
- Sticky flag: boundary event in the same cycle as ovf_clr=1 -> ovf stays 1. ovf_clr alone next cycle -> ovf=0.
- Async reset: assert reset mid-cycle at count=0x37 -> count, tc and ovf go to 0 before the next edge. After release with prescale=2, the first increment occurs on the 3rd enabled cycle.
